req_ack_elastic_fifo: RTL and testbench
=======================================

Name: req_ack_elastic_fifo

Overview:
- Elastic FIFO stage between an arf output port (dout_req_N / dout_ack_N / dout_N) and a consumer in the dataflow simulation benches.
- Upstream side behaves as a consumer: it drives req and takes ack plus data. Downstream side behaves as a producer: it takes req and drives a one-cycle ack plus data.
- Decouples graph output timing from sink stalls and exposes occupancy and transfer counters for throughput measurement.

Parameters:
- data_width, 32, width of the data word.
- depth, 4, number of storage entries; must be a power of two, >= 2.
- addr_width, 2, log2(depth); pointer width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- req_l  output  1  request to the upstream sender (the arf dout_req_N side).
- ack_l  input  1  upstream ack; one-cycle pulse, data valid on din while high.
- din  input  data_width  upstream data.
- req_r  input  1  downstream request from the consumer.
- ack_r  output  1  downstream ack; one-cycle pulse.
- dout  output  data_width  downstream data, valid while ack_r=1, held otherwise.
- level  output  addr_width+1  current occupancy, 0..depth.
- full  output  1  level==depth.
- empty  output  1  level==0.
- count_in  output  32  words accepted from upstream.
- count_out  output  32  words delivered downstream.

Behaviour:
- Reset: rst and clk as already decided (synchronous, active-high rst; clock clk). While rst=1 at an edge:
  - req_l=0, ack_r=0, dout=0, level=0, count_in=0, count_out=0, read/write pointers=0.
  - ack_l sampled during reset is ignored.
  - Reset mid-operation discards all stored words; no stored word is ever emitted afterwards.
- Registers and flags:
  - All outputs are registered.
  - full and empty are derived combinationally from the level register.
- Upstream handshake (single outstanding request):
  - At an edge with req_l=0, ack_l=0 and level<depth: req_l<=1.
  - At an edge with ack_l=1: mem[wr_ptr]<=din, wr_ptr<=wr_ptr+1 (mod depth), req_l<=0, count_in<=count_in+1.
  - Data is captured on clk only, never on an ack_l edge.
  - While full, req_l stays 0.
  - Because req_l is raised only when level<depth and at most one request is outstanding, overflow cannot occur.
  - ack_l arriving while req_l=0 is a protocol error: the word is still written if level<depth, otherwise dropped. This case is not exercised in normal benches.
- Downstream handshake:
  - At an edge with req_r=1, ack_r=0 and level>0: ack_r<=1, dout<=mem[rd_ptr], rd_ptr<=rd_ptr+1 (mod depth), count_out<=count_out+1.
  - Otherwise ack_r<=0 and dout holds its value.
  - Maximum downstream rate is one word every 2 cycles.
- Level update:
  - push only: +1; pop only: -1; push and pop at the same edge: unchanged.
  - The pop decision uses the registered level, so a word written at edge E can be popped no earlier than edge E+1.
- Latency:
  - Empty FIFO, req_r held 1, ack_l sampled at edge E: ack_r=1 with that data after edge E+1.
  - req_l re-asserts after edge E+1 if level<depth.
- Boundaries:
  - Pointers wrap modulo depth.
  - Counters wrap modulo 2^32.
  - Empty: no ack_r regardless of req_r.
  - Full plus pop at the same edge: level becomes depth-1, and req_l rises at the following edge.
- Ordering: strict FIFO order. Data values are passed through unmodified.

Test Plan:
- Reset: hold rst 2 cycles with ack_l=1 and din=0x55 → all outputs 0, level 0. The first edge after release gives req_l=1, and 0x55 is never emitted.
- Fill/drain, depth 4, req_r=0: upstream acks din 10,11,12,13 → level=4, full=1, req_l stays 0. Then set req_r=1 → ack_r pulses every other cycle with dout 10,11,12,13, then level 0, empty=1, count_in=count_out=4.
- Latency: empty FIFO, req_r=1, single ack_l with din=0xA5 at edge E → ack_r=1 with dout=0xA5 after edge E+1, exactly one pulse.
- Simultaneous push/pop: at level 2 (holding 20,21), push 22 on the same edge as pop → level stays 2, dout=20, and subsequent outputs are 21,22.
- Wrap-around: stream din 0..9 through depth 4 with both sides active → dout sequence 0..9 in order, count_in=count_out=10, pointers have wrapped twice.
- Reset mid-operation at level 3 (words 30,31,32) → level 0, ack_r 0. After release, upstream acks 40 → first dout emitted is 40.

Source files
------------

// File: rtl/req_ack_elastic_fifo.sv
// Elastic FIFO stage between an arf output port and a dataflow consumer.
//
// Upstream side acts as a consumer: it raises req_l, the sender answers with a
// one-cycle ack_l pulse carrying din. Downstream side acts as a producer: on
// req_r it answers with a one-cycle ack_r pulse carrying dout.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_l  (out)      request to upstream sender, at most one outstanding
//   ack_l  (in)       upstream ack pulse, din valid while high
//   din    (in)       upstream data
//   req_r  (in)       downstream request
//   ack_r  (out)      downstream ack pulse, dout valid while high
//   dout   (out)      downstream data, held between pulses
//   level  (out)      occupancy 0..depth
//   full, empty (out) decoded from level
//   count_in/out (out) words accepted / delivered, wrap modulo 2^32
module req_ack_elastic_fifo #(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic [31:0]           count_in,
  output logic [31:0]           count_out
);

  localparam logic [addr_width:0] LevelMax = (addr_width + 1)'(depth);

  logic [data_width-1:0] mem [depth];
  logic [addr_width-1:0] wr_ptr;
  logic [addr_width-1:0] rd_ptr;
  logic                  push;
  logic                  pop;

  assign full  = (level == LevelMax);
  assign empty = (level == '0);

  // A stray ack_l without a request is still stored while there is room.
  assign push = ack_l && !full;
  // Pop decision uses the registered level, so a word is poppable one edge
  // after it was written; the !ack_r term limits output to every other cycle.
  assign pop  = req_r && !ack_r && !empty;

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_l     <= 1'b0;
      ack_r     <= 1'b0;
      dout      <= '0;
      level     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_in  <= '0;
      count_out <= '0;
    end else begin
      if (ack_l) begin
        req_l <= 1'b0;
      end else if (!req_l && !full) begin
        req_l <= 1'b1;
      end

      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        count_in <= count_in + 32'd1;
      end

      if (pop) begin
        ack_r     <= 1'b1;
        dout      <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
        count_out <= count_out + 32'd1;
      end else begin
        ack_r <= 1'b0;
      end

      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_req_ack_elastic_fifo.sv
module tb_req_ack_elastic_fifo;

  logic        clk;
  logic        rst;
  logic        req_l;
  logic        ack_l;
  logic [31:0] din;
  logic        req_r;
  logic        ack_r;
  logic [31:0] dout;
  logic [2:0]  level;
  logic        full;
  logic        empty;
  logic [31:0] count_in;
  logic [31:0] count_out;

  int          tests;
  int          fails;
  int          pulses;
  logic [31:0] exp_q [$];

  req_ack_elastic_fifo #(
    .data_width(32),
    .depth     (4),
    .addr_width(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_l    (req_l),
    .ack_l    (ack_l),
    .din      (din),
    .req_r    (req_r),
    .ack_r    (ack_r),
    .dout     (dout),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .count_in (count_in),
    .count_out(count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every downstream pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && ack_r) begin
      pulses++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack_r: got dout=%0h, expected no output", dout);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          fails++;
          $display("FAIL scoreboard_dout: got %0h, expected %0h", dout, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    ack_l = 1'b0;
    req_r = 1'b0;
    exp_q.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for req_l, then deliver one word with a single-cycle ack.
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    while (req_l !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (req_l !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: req_l=%b after %0d cycles, expected 1", req_l, n);
    end else begin
      ack_l = 1'b1;
      din   = d;
      exp_q.push_back(d);
      step();
      ack_l = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    ack_l = 1'b1;
    din   = 32'h55;
    req_r = 1'b1;
    pulses = 0;
    step();
    step();
    tests++;
    if ({req_l, ack_r, dout, level, count_in, count_out, empty} !== {1'b0, 1'b0, 32'h0, 3'd0, 32'h0, 32'h0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: req_l=%b ack_r=%b dout=%0h level=%0d cin=%0d cout=%0d empty=%b, expected all 0 and empty=1",
               req_l, ack_r, dout, level, count_in, count_out, empty);
    end
    rst   = 1'b0;
    ack_l = 1'b0;
    step();
    tests++;
    if (req_l !== 1'b1) begin
      fails++;
      $display("FAIL reset_req_l_rise: got %b, expected 1", req_l);
    end
    repeat (5) step();
    tests++;
    if (pulses !== 0 || level !== 3'd0) begin
      fails++;
      $display("FAIL reset_no_emit: pulses=%0d level=%0d, expected 0 and 0", pulses, level);
    end
    req_r = 1'b0;
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 10; i <= 13; i++) send(32'(i));
    repeat (3) step();
    tests++;
    if (level !== 3'd4 || full !== 1'b1 || req_l !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: level=%0d full=%b req_l=%b, expected 4 1 0", level, full, req_l);
    end
    req_r = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      tests++;
      if (ack_r !== ((i % 2) == 0)) begin
        fails++;
        $display("FAIL drain_pulse_%0d: ack_r=%b, expected %b", i, ack_r, (i % 2) == 0);
      end
    end
    step();
    req_r = 1'b0;
    tests++;
    if (level !== 3'd0 || empty !== 1'b1 || count_in !== 32'd4 || count_out !== 32'd4 ||
        exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_final: level=%0d empty=%b cin=%0d cout=%0d left=%0d, expected 0 1 4 4 0",
               level, empty, count_in, count_out, exp_q.size());
    end
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    req_r  = 1'b1;
    pulses = 0;
    n = 0;
    while (req_l !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    ack_l = 1'b1;
    din   = 32'hA5;
    exp_q.push_back(32'hA5);
    step();
    ack_l = 1'b0;
    tests++;
    if (ack_r !== 1'b0) begin
      fails++;
      $display("FAIL latency_early: ack_r=%b after edge E, expected 0", ack_r);
    end
    step();
    tests++;
    if (ack_r !== 1'b1 || dout !== 32'hA5) begin
      fails++;
      $display("FAIL latency_e1: ack_r=%b dout=%0h after edge E+1, expected 1 a5", ack_r, dout);
    end
    repeat (5) step();
    req_r = 1'b0;
    tests++;
    if (pulses !== 1) begin
      fails++;
      $display("FAIL latency_single_pulse: pulses=%0d, expected 1", pulses);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    do_reset();
    send(32'd20);
    send(32'd21);
    n = 0;
    while (req_l !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (level !== 3'd2) begin
      fails++;
      $display("FAIL simul_pre_level: level=%0d, expected 2", level);
    end
    ack_l = 1'b1;
    din   = 32'd22;
    req_r = 1'b1;
    exp_q.push_back(32'd22);
    step();
    ack_l = 1'b0;
    tests++;
    if (level !== 3'd2 || ack_r !== 1'b1 || dout !== 32'd20) begin
      fails++;
      $display("FAIL simul_push_pop: level=%0d ack_r=%b dout=%0d, expected 2 1 20",
               level, ack_r, dout);
    end
    repeat (8) step();
    req_r = 1'b0;
    tests++;
    if (level !== 3'd0 || count_in !== 32'd3 || count_out !== 32'd3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL simul_final: level=%0d cin=%0d cout=%0d left=%0d, expected 0 3 3 0",
               level, count_in, count_out, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req_r = 1'b1;
    for (int i = 0; i < 10; i++) send(32'(i));
    repeat (10) step();
    req_r = 1'b0;
    tests++;
    if (count_in !== 32'd10 || count_out !== 32'd10 || level !== 3'd0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL wrap_final: cin=%0d cout=%0d level=%0d left=%0d, expected 10 10 0 0",
               count_in, count_out, level, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(32'd30);
    send(32'd31);
    send(32'd32);
    step();
    tests++;
    if (level !== 3'd3) begin
      fails++;
      $display("FAIL mid_pre_level: level=%0d, expected 3", level);
    end
    rst   = 1'b1;
    req_r = 1'b1;
    exp_q.delete();
    step();
    step();
    tests++;
    if (level !== 3'd0 || ack_r !== 1'b0 || count_in !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset_state: level=%0d ack_r=%b cin=%0d, expected 0 0 0",
               level, ack_r, count_in);
    end
    rst    = 1'b0;
    pulses = 0;
    send(32'd40);
    repeat (6) step();
    req_r = 1'b0;
    tests++;
    if (pulses !== 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL mid_after: pulses=%0d left=%0d, expected 1 0", pulses, exp_q.size());
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    pulses = 0;
    rst    = 1'b1;
    ack_l  = 1'b0;
    req_r  = 1'b0;
    din    = '0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
